// File: rtl/modulo_residual_pipe_pkg.sv
// modres_pkg: shared widths, channel-tag width helper and the pipeline stage
// record for the centered-modulo residual unit. The datapath widths are fixed
// here, and every file of the block follows them.
// Optional feature macro: MODRES_OVF_EN (quotient overflow detection).

package modres_pkg;

    localparam int WIDTH    = 32;
    localparam int KBITS    = 8;
    localparam int CHANNELS = 4;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_W = ch_width(CHANNELS);
    localparam int SW   = WIDTH + 1;
    localparam int RW   = WIDTH + 2;
    localparam int FW   = KBITS + 2;

    // One pipeline slot. a is the dividend |s|, r the running partial
    // remainder, and q collects quotient bits MSB first.
    typedef struct packed {
        logic             valid;
        logic [CH_W-1:0]  chan;
        logic             neg;
        logic             zero;
        logic             ovf;
        logic [SW-1:0]    a;
        logic [WIDTH-1:0] m;
        logic [KBITS-1:0] q;
        logic [SW-1:0]    r;
        logic [WIDTH-1:0] diff;
        logic [WIDTH-1:0] lambda;
    } stage_t;

endpackage

// File: rtl/modulo_residual_pipe_if.sv
// Sample/residual bus of modulo_residual_pipe. master drives samples and
// consumes residuals; slave is the residual unit itself.
// Optional feature macro: MODRES_OVF_EN adds ovf_out.

interface modulo_residual_pipe_if;
    import modres_pkg::*;

    logic             valid_in;
    logic [CH_W-1:0]  chan_in;
    logic [WIDTH-1:0] diff_in;
    logic [WIDTH-1:0] lambda_in;

    logic             valid_out;
    logic [CH_W-1:0]  chan_out;
    logic [WIDTH-1:0] residual_out;
    logic [FW-1:0]    fold_out;
`ifdef MODRES_OVF_EN
    logic             ovf_out;
`endif

`ifdef MODRES_OVF_EN
    modport master (
        output valid_in, chan_in, diff_in, lambda_in,
        input  valid_out, chan_out, residual_out, fold_out, ovf_out
    );
    modport slave (
        input  valid_in, chan_in, diff_in, lambda_in,
        output valid_out, chan_out, residual_out, fold_out, ovf_out
    );
`else
    modport master (
        output valid_in, chan_in, diff_in, lambda_in,
        input  valid_out, chan_out, residual_out, fold_out
    );
    modport slave (
        input  valid_in, chan_in, diff_in, lambda_in,
        output valid_out, chan_out, residual_out, fold_out
    );
`endif

endinterface

// File: rtl/modulo_residual_pipe_div_stage.sv
// modres_div_stage: one registered restoring-division step. It shifts the next
// dividend bit a[BIT] into the partial remainder, subtracts the divisor m and
// keeps the difference when it is non-negative, setting quotient bit BIT.

module modres_div_stage
    import modres_pkg::*;
#(
    parameter int BIT = 0
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   clk_en,
    input  stage_t cur,
    output stage_t nxt
);

    logic [SW-1:0] shifted;
    logic [SW:0]   trial;
    stage_t        step;

    // Trial subtraction of m from the shifted remainder; the sign bit of the
    // difference decides the quotient bit and whether to restore.
    always_comb begin
        shifted = {cur.r[SW-2:0], cur.a[BIT]};
        trial   = {1'b0, shifted} - {2'b00, cur.m};
        step    = cur;
        if (!trial[SW]) begin
            step.r      = trial[SW-1:0];
            step.q[BIT] = 1'b1;
        end else begin
            step.r      = shifted;
            step.q[BIT] = 1'b0;
        end
    end

    // Slot register; only the valid bit needs clearing on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            nxt.valid <= 1'b0;
        end else if (clk_en) begin
            nxt <= step;
        end
    end

endmodule

// File: rtl/modulo_residual_pipe.sv
// modulo_residual_pipe: fully pipelined centered-modulo residual unit.
// residual = [diff]_lambda - diff with the fold onto [-lambda, lambda), and the
// signed fold count k such that residual = -2*lambda*k. Latency KBITS+2
// enabled cycles, one sample per enabled cycle, no back-pressure.
// Optional feature macro: MODRES_OVF_EN (flags samples whose quotient does not
// fit in KBITS bits and forces their residual/fold to zero).

module modulo_residual_pipe
    import modres_pkg::*;
(
    input logic                  clk,
    input logic                  reset,
    input logic                  clk_en,
    modulo_residual_pipe_if.slave bus
);

    logic [SW-1:0]    s0_s;
    logic [SW-1:0]    s0_a;
    logic [WIDTH-1:0] s0_m;
    stage_t           s0_next;
    stage_t           s0_q;
    stage_t           chain [0:KBITS];

    logic [FW-1:0]    q_ext;
    logic [WIDTH-1:0] mod_pos;
    logic [FW-1:0]    fold_n;
    logic [WIDTH-1:0] res_n;
`ifdef MODRES_OVF_EN
    logic             ovf_n;
`endif

    // Input stage: shift into [0, 2*lambda) by adding lambda, then split the
    // sum into sign and magnitude so the divider only sees unsigned values.
    // The partial remainder starts as the dividend bits above the KBITS
    // quotient positions; that is below m exactly when no overflow occurs.
    always_comb begin
        s0_s           = {bus.diff_in[WIDTH-1], bus.diff_in} + {1'b0, bus.lambda_in};
        s0_a           = s0_s[SW-1] ? (~s0_s + 1'b1) : s0_s;
        s0_m           = {bus.lambda_in[WIDTH-2:0], 1'b0};
        s0_next        = '0;
        s0_next.valid  = bus.valid_in;
        s0_next.chan   = bus.chan_in;
        s0_next.neg    = s0_s[SW-1];
        s0_next.zero   = (bus.lambda_in == '0);
        s0_next.a      = s0_a;
        s0_next.m      = s0_m;
        s0_next.q      = '0;
        s0_next.r      = s0_a >> KBITS;
        s0_next.diff   = bus.diff_in;
        s0_next.lambda = bus.lambda_in;
`ifdef MODRES_OVF_EN
        s0_next.ovf    = (bus.lambda_in != '0) && ((s0_a >> KBITS) >= {1'b0, s0_m});
`else
        s0_next.ovf    = 1'b0;
`endif
    end

    // Input register; data may update on bubbles, only valid is reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_q.valid <= 1'b0;
        end else if (clk_en) begin
            s0_q <= s0_next;
        end
    end

    assign chain[0] = s0_q;

    genvar gi;
    generate
        for (gi = 0; gi < KBITS; gi++) begin : g_div
            modres_div_stage #(
                .BIT (KBITS - 1 - gi)
            ) u_stage (
                .clk    (clk),
                .reset  (reset),
                .clk_en (clk_en),
                .cur    (chain[gi]),
                .nxt    (chain[gi+1])
            );
        end
    endgenerate

    // Convert the magnitude quotient/remainder back to a floor division of
    // the signed sum, then form mod_pos - lambda - diff. The subtraction is
    // done at WIDTH bits since only the wrapped low bits are kept anyway.
    always_comb begin
        q_ext   = {2'b00, chain[KBITS].q};
        mod_pos = chain[KBITS].r[WIDTH-1:0];
        fold_n  = q_ext;
        if (chain[KBITS].neg) begin
            if (chain[KBITS].r == '0) begin
                fold_n  = -q_ext;
                mod_pos = '0;
            end else begin
                fold_n  = -(q_ext + FW'(1));
                mod_pos = chain[KBITS].m - chain[KBITS].r[WIDTH-1:0];
            end
        end
        res_n = mod_pos - chain[KBITS].lambda - chain[KBITS].diff;
`ifdef MODRES_OVF_EN
        ovf_n = 1'b0;
`endif
        if (chain[KBITS].zero) begin
            res_n  = '0;
            fold_n = '0;
        end
`ifdef MODRES_OVF_EN
        else if (chain[KBITS].ovf) begin
            res_n  = '0;
            fold_n = '0;
            ovf_n  = 1'b1;
        end
`endif
    end

    // Output register; reset clears every output and wins over clk_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.valid_out    <= 1'b0;
            bus.chan_out     <= '0;
            bus.residual_out <= '0;
            bus.fold_out     <= '0;
`ifdef MODRES_OVF_EN
            bus.ovf_out      <= 1'b0;
`endif
        end else if (clk_en) begin
            bus.valid_out    <= chain[KBITS].valid;
            bus.chan_out     <= chain[KBITS].chan;
            bus.residual_out <= res_n;
            bus.fold_out     <= fold_n;
`ifdef MODRES_OVF_EN
            bus.ovf_out      <= ovf_n;
`endif
        end
    end

endmodule

// File: tb/tb_modulo_residual_pipe.sv
// tb_modulo_residual_pipe: scoreboard bench for modulo_residual_pipe.
// Expected results come from an integer floor-division model and are queued
// as samples are captured; they are popped when valid_out appears.
// Optional feature macro: MODRES_OVF_EN (adds overflow expectations).

module tb_modulo_residual_pipe;
    import modres_pkg::*;

    localparam int LATENCY = KBITS + 2;

    logic clk = 1'b0;
    logic reset;
    logic clk_en;

    modulo_residual_pipe_if bus();

    modulo_residual_pipe dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH_W-1:0]  chan;
        logic [WIDTH-1:0] res;
        logic [FW-1:0]    fold;
        logic             ovf;
        longint           issue;
    } exp_t;

    exp_t   sb[$];
    int     tests_run    = 0;
    int     tests_failed = 0;
    longint en_count     = 0;
    bit     hold_edge    = 1'b0;
    bit     snap_ok      = 1'b0;
    bit     rand_en      = 1'b0;

    logic             snap_valid;
    logic [CH_W-1:0]  snap_chan;
    logic [WIDTH-1:0] snap_res;
    logic [FW-1:0]    snap_fold;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t model(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] d,
                                   input logic [WIDTH-1:0] l);
        longint sd, ll, s, m, k, modv, res;
        exp_t   e;
        sd      = longint'($signed(d));
        ll      = longint'(l);
        e.chan  = ch;
        e.ovf   = 1'b0;
        e.issue = 0;
        e.res   = '0;
        e.fold  = '0;
        if (ll == 0) return e;
        s = sd + ll;
        m = 2 * ll;
        if (s >= 0) k = s / m;
        else        k = -((-s + m - 1) / m);
`ifdef MODRES_OVF_EN
        if (((s < 0) ? -s : s) >= m * (longint'(1) << KBITS)) begin
            e.ovf = 1'b1;
            return e;
        end
`endif
        modv   = s - k * m;
        res    = modv - ll - sd;
        e.res  = res[WIDTH-1:0];
        e.fold = k[FW-1:0];
        return e;
    endfunction

    // Capture side: queue the expected result of every accepted sample.
    always @(posedge clk) begin
        exp_t e;
        hold_edge = !reset && !clk_en;
        if (reset) begin
            sb.delete();
        end else if (clk_en) begin
            if (bus.valid_in) begin
                e       = model(bus.chan_in, bus.diff_in, bus.lambda_in);
                e.issue = en_count;
                sb.push_back(e);
            end
            en_count++;
        end
    end

    // Output side: compare results on enabled edges, check hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (hold_edge) begin
            if (snap_ok) begin
                checkOutput("hold_valid", 64'(bus.valid_out), 64'(snap_valid));
                checkOutput("hold_chan", 64'(bus.chan_out), 64'(snap_chan));
                checkOutput("hold_residual", 64'(bus.residual_out), 64'(snap_res));
                checkOutput("hold_fold", 64'(bus.fold_out), 64'(snap_fold));
            end
        end else if (bus.valid_out) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                checkOutput("residual", 64'(bus.residual_out), 64'(e.res));
                checkOutput("fold", 64'(bus.fold_out), 64'(e.fold));
                checkOutput("chan", 64'(bus.chan_out), 64'(e.chan));
                checkOutput("latency", 64'(en_count - e.issue), 64'(LATENCY));
`ifdef MODRES_OVF_EN
                checkOutput("ovf", 64'(bus.ovf_out), 64'(e.ovf));
`endif
            end
        end
        snap_valid = bus.valid_out;
        snap_chan  = bus.chan_out;
        snap_res   = bus.residual_out;
        snap_fold  = bus.fold_out;
        snap_ok    = 1'b1;
    end

    // Pseudo-random clk_en while the random stream runs.
    always @(negedge clk) begin
        if (rand_en) clk_en = ($urandom_range(0, 2) != 0);
    end

    task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] d,
                                 input logic [WIDTH-1:0] l);
        int guard = 0;
        @(negedge clk);
        bus.valid_in  = 1'b1;
        bus.chan_in   = ch;
        bus.diff_in   = d;
        bus.lambda_in = l;
        do begin
            @(posedge clk);
            guard++;
        end while (!clk_en && guard < 100);
        if (!clk_en) checkOutput("capture_timeout", 64'(1), 64'(0));
    endtask

    task automatic idleCycle();
        @(negedge clk);
        bus.valid_in = 1'b0;
    endtask

    task automatic drainPipe();
        int n = 0;
        idleCycle();
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_pending", 64'(sb.size()), 64'(0));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 64'(bus.valid_out), 64'(0));
        checkOutput({tag, "_chan"}, 64'(bus.chan_out), 64'(0));
        checkOutput({tag, "_residual"}, 64'(bus.residual_out), 64'(0));
        checkOutput({tag, "_fold"}, 64'(bus.fold_out), 64'(0));
`ifdef MODRES_OVF_EN
        checkOutput({tag, "_ovf"}, 64'(bus.ovf_out), 64'(0));
`endif
    endtask

    initial begin
        longint l, dd;
        reset         = 1'b1;
        clk_en        = 1'b1;
        bus.valid_in  = 1'b0;
        bus.chan_in   = '0;
        bus.diff_in   = '0;
        bus.lambda_in = '0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;

        // lambda = 3 back-to-back sequence
        applyStimulus(CH_W'(0), WIDTH'(7), WIDTH'(3));
        applyStimulus(CH_W'(0), WIDTH'(2), WIDTH'(3));
        applyStimulus(CH_W'(0), WIDTH'(-3), WIDTH'(3));
        applyStimulus(CH_W'(0), WIDTH'(3), WIDTH'(3));
        applyStimulus(CH_W'(0), WIDTH'(-4), WIDTH'(3));
        drainPipe();

        // channel tags with per-sample lambda
        for (int i = 0; i < 4; i++)
            applyStimulus(CH_W'(i), WIDTH'(5), WIDTH'(i + 1));
        drainPipe();

        // boundaries: lambda = 0, interval edges, largest folds, extreme inputs
        applyStimulus(CH_W'(1), WIDTH'(1234), WIDTH'(0));
        applyStimulus(CH_W'(2), WIDTH'(500), WIDTH'(1));
        applyStimulus(CH_W'(3), WIDTH'(510), WIDTH'(1));
        applyStimulus(CH_W'(0), WIDTH'(-510), WIDTH'(1));
        applyStimulus(CH_W'(1), WIDTH'(-5), WIDTH'(5));
        applyStimulus(CH_W'(2), WIDTH'(5), WIDTH'(5));
        applyStimulus(CH_W'(3), WIDTH'(32'h8000_0000), WIDTH'(32'h3FFF_FFFF));
        applyStimulus(CH_W'(0), WIDTH'(32'h7FFF_FFFF), WIDTH'(32'h3FFF_FFFF));
`ifdef MODRES_OVF_EN
        applyStimulus(CH_W'(1), WIDTH'(600), WIDTH'(1));
        applyStimulus(CH_W'(2), WIDTH'(-600), WIDTH'(1));
`endif
        drainPipe();

        // random stream with clk_en toggling and occasional bubbles
        rand_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            l  = longint'($urandom_range(1, 1 << 20));
            dd = longint'($urandom_range(0, 32'(400 * l))) - 200 * l;
            applyStimulus(CH_W'(i % CHANNELS), dd[WIDTH-1:0], l[WIDTH-1:0]);
            if ($urandom_range(0, 3) == 0) idleCycle();
        end
        drainPipe();
        @(negedge clk);
        rand_en = 1'b0;
        clk_en  = 1'b1;

        // reset with samples in flight, clk_en low to show reset wins
        for (int i = 0; i < 5; i++)
            applyStimulus(CH_W'(i % CHANNELS), WIDTH'(100 * i + 7), WIDTH'(9));
        @(negedge clk);
        bus.valid_in = 1'b0;
        reset        = 1'b1;
        clk_en       = 1'b0;
        @(negedge clk);
        checkResetState("flush");
        checkOutput("flush_queue", 64'(sb.size()), 64'(0));
        reset  = 1'b0;
        clk_en = 1'b1;
        repeat (LATENCY + 5) @(negedge clk);
        applyStimulus(CH_W'(2), WIDTH'(-17), WIDTH'(4));
        drainPipe();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
